// File: rtl/servo_pwm.sv
// servo_pwm: fixed-period servo PWM whose pulse width is linear in a 3-bit position.
//
// Parameters:
//   PERIODO      clocks per PWM period
//   LARGURA_MIN  pulse width in clocks for position 0
//   PASSO        extra pulse clocks per position step
//
// Ports:
//   clock          system clock, rising edge
//   zera_s         synchronous active-high reset
//   liga           pulse enable, sampled at the period boundary
//   carrega        one-cycle strobe loading posicao
//   posicao        requested position 0..7
//   pwm            registered servo drive
//   posicao_atual  position in effect for the current period
//   fim_periodo    high in the last cycle of each period
//   pendente       a loaded position waits for the next period
module servo_pwm #(
    parameter int PERIODO     = 1000000,
    parameter int LARGURA_MIN = 50000,
    parameter int PASSO       = 7143
) (
    input  logic       clock,
    input  logic       zera_s,
    input  logic       liga,
    input  logic       carrega,
    input  logic [2:0] posicao,
    output logic       pwm,
    output logic [2:0] posicao_atual,
    output logic       fim_periodo,
    output logic       pendente
);
    localparam int CW = $clog2(PERIODO);

    logic [CW-1:0] cnt, cnt_n, largura, largura_n;
    logic [2:0]    sombra, sombra_n, pos_n;
    logic          ativo, ativo_n, pend_n, fronteira;

    // Every register is updated from these next-state values, so pwm and
    // fim_periodo line up with the cnt value they describe.
    always_comb begin
        fronteira = cnt == CW'(PERIODO - 1);
        cnt_n     = fronteira ? '0 : cnt + 1'b1;
        sombra_n  = carrega ? posicao : sombra;
        // a load in the boundary cycle bypasses the shadow register
        pos_n     = !fronteira ? posicao_atual :
                    carrega    ? posicao :
                    pendente   ? sombra : posicao_atual;
        pend_n    = !fronteira && (carrega || pendente);
        ativo_n   = fronteira ? liga : ativo;
        largura_n = fronteira ? CW'(LARGURA_MIN) + CW'(PASSO) * CW'(pos_n) : largura;
    end

    always_ff @(posedge clock) begin
        if (zera_s) begin
            cnt           <= '0;
            largura       <= CW'(LARGURA_MIN);
            sombra        <= '0;
            posicao_atual <= '0;
            ativo         <= 1'b0;
            pendente      <= 1'b0;
            pwm           <= 1'b0;
            fim_periodo   <= 1'b0;
        end else begin
            cnt           <= cnt_n;
            largura       <= largura_n;
            sombra        <= sombra_n;
            posicao_atual <= pos_n;
            ativo         <= ativo_n;
            pendente      <= pend_n;
            pwm           <= ativo_n && (cnt_n < largura_n);
            fim_periodo   <= cnt_n == CW'(PERIODO - 1);
        end
    end
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: directed self-checking bench for servo_pwm with PERIODO=20, LARGURA_MIN=4, PASSO=2.
module tb_servo_pwm;
    localparam int P = 20;

    logic       clock = 1'b0;
    logic       zera_s = 1'b1;
    logic       liga = 1'b0;
    logic       carrega = 1'b0;
    logic [2:0] posicao = '0;
    logic       pwm, fim_periodo, pendente;
    logic [2:0] posicao_atual;
    int         n_tests = 0;
    int         n_fail = 0;

    servo_pwm #(.PERIODO(P), .LARGURA_MIN(4), .PASSO(2)) dut (
        .clock(clock),
        .zera_s(zera_s),
        .liga(liga),
        .carrega(carrega),
        .posicao(posicao),
        .pwm(pwm),
        .posicao_atual(posicao_atual),
        .fim_periodo(fim_periodo),
        .pendente(pendente)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one full period starting at cnt=0. Loads posicao la_v at cycle la
    // and lb_v at cycle lb; sets liga to lg_v at cycle lg (-1 disables each).
    task automatic run_period(input string tag, input int exp_w, input int exp_pa,
                              input int la, input int la_v, input int lb, input int lb_v,
                              input int lg, input logic lg_v, output logic [P-1:0] pend);
        int lead = 0;
        int total = 0;
        int nfim = 0;
        int fpos = -1;
        logic run = 1'b1;
        chk({tag, "_pa"}, int'(posicao_atual), exp_pa);
        for (int i = 0; i < P; i++) begin
            pend[i] = pendente;
            if (pwm) total++;
            if (pwm && run) lead++; else run = 1'b0;
            if (fim_periodo) begin nfim++; fpos = i; end
            carrega = (i == la) || (i == lb);
            posicao = (i == la) ? 3'(la_v) : 3'(lb_v);
            if (i == lg) liga = lg_v;
            tick();
            carrega = 1'b0;
        end
        chk({tag, "_width"}, lead, exp_w);
        chk({tag, "_total"}, total, exp_w);
        chk({tag, "_nfim"}, nfim, 1);
        chk({tag, "_fimpos"}, fpos, P - 1);
    endtask

    initial begin
        logic [P-1:0] pd;
        int seq [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
        liga = 1'b1;
        carrega = 1'b1;
        posicao = 3'd6;
        tick();
        tick();
        zera_s = 1'b0;
        carrega = 1'b0;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_fim", int'(fim_periodo), 0);
        chk("rst_pend", int'(pendente), 0);
        chk("rst_pa", int'(posicao_atual), 0);
        run_period("p1_idle", 0, 0, -1, 0, -1, 0, -1, 1'b1, pd);
        run_period("p2_base", 4, 0, 8, 5, -1, 0, -1, 1'b1, pd);
        chk("p2_pend8", int'(pd[8]), 0);
        chk("p2_pend9", int'(pd[9]), 1);
        run_period("p3_pos5", 14, 5, 2, 3, 10, 6, -1, 1'b1, pd);
        chk("p3_pend0", int'(pd[0]), 0);
        chk("p3_pend3", int'(pd[3]), 1);
        run_period("p4_pos6", 16, 6, 19, 7, -1, 0, -1, 1'b1, pd);
        chk("p4_pend19", int'(pd[19]), 0);
        run_period("p5_bypass7", 18, 7, 19, 5, -1, 0, -1, 1'b1, pd);
        chk("p5_pend0", int'(pd[0]), 0);
        run_period("p6_ligaoff", 14, 5, -1, 0, -1, 0, 2, 1'b0, pd);
        run_period("p7_off", 0, 5, -1, 0, -1, 0, -1, 1'b0, pd);
        run_period("p8_ligaon", 0, 5, -1, 0, -1, 0, 7, 1'b1, pd);
        for (int i = 0; i < 5; i++) begin
            chk("p9_pulse", int'(pwm), 1);
            tick();
        end
        chk("p9_pulse5", int'(pwm), 1);
        zera_s = 1'b1;
        tick();
        zera_s = 1'b0;
        chk("midrst_pwm", int'(pwm), 0);
        chk("midrst_pa", int'(posicao_atual), 0);
        chk("midrst_fim", int'(fim_periodo), 0);
        run_period("post_rst", 0, 0, -1, 0, -1, 0, -1, 1'b1, pd);
        run_period("sweep_pre", 4, 0, 19, seq[0], -1, 0, -1, 1'b1, pd);
        for (int k = 0; k < 14; k++)
            run_period($sformatf("sweep%0d", k), 4 + 2 * seq[k], seq[k],
                       (k < 13) ? 19 : -1, (k < 13) ? seq[k + 1] : 0, -1, 0, -1, 1'b1, pd);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/servo_pwm.md
# servo_pwm

Servo PWM generator for the servo sweep path. It consumes the 3-bit position index produced by the up/down position sequencer (values 0..7) and drives a fixed-period PWM pulse. The pulse width is linear in the position. A new position is buffered when it is loaded and takes effect only at the next period boundary, so no period ever carries a truncated or stretched pulse.

## Interface
Parameters:
- PERIODO, default 1000000: clocks per PWM period (20 ms at 50 MHz).
- LARGURA_MIN, default 50000: pulse width in clocks for position 0 (1 ms).
- PASSO, default 7143: extra clocks per position step (position 7 gives about 2 ms).
- Constraint: LARGURA_MIN + 7*PASSO < PERIODO. The counter width is $clog2(PERIODO).

Ports:
- clock, input, 1: system clock; everything is on the rising edge.
- zera_s, input, 1: reset, synchronous and active-high.
- liga, input, 1: enable pulse output. Sampled only at period start.
- carrega, input, 1: single-cycle strobe that loads `posicao`.
- posicao, input, 3: requested position 0..7, valid when `carrega`=1.
- pwm, output, 1: servo drive. Registered and glitch-free.
- posicao_atual, output, 3: position in effect for the current period.
- fim_periodo, output, 1: high for one clock in the last cycle of each period.
- pendente, output, 1: a loaded position is waiting for the next period.

## Operation
- Period counter `cnt` counts 0..PERIODO-1 and wraps to 0. It free-runs whether `liga` is high or low.
- Load buffer:
  - `carrega`=1 writes `posicao` into the shadow register and sets `pendente`=1.
  - A later load in the same period overwrites the earlier one (last write wins).
- Period boundary (cycle where `cnt`=PERIODO-1), with the new values visible from `cnt`=0 onward:
  - If `carrega`=1 in this cycle, that `posicao` is applied directly (bypass).
  - Otherwise, if `pendente`=1, the shadow value is applied.
  - Otherwise, `posicao_atual` is kept.
  - `pendente` clears.
  - `ativo` is set to `liga`.
  - `largura` becomes LARGURA_MIN + posicao_atual*PASSO. Compute it at the width of `cnt`; no overflow occurs, given the parameter constraint.
- Output: `pwm`=1 exactly when `ativo`=1 and `cnt` < `largura` in the same cycle. Implement it as a register driven from next-state values.
- `liga` dropping mid-period: the current pulse completes. `pwm` stays 0 from the next period on.
- `liga` rising mid-period: no pulse until the next period start.
- `fim_periodo` = (`cnt` == PERIODO-1), registered so it aligns with that cycle.
- Reset (`zera_s`=1 at an edge; it overrides all other inputs) takes effect on the next cycle:
  - `cnt`=0, `pwm`=0, `fim_periodo`=0, `pendente`=0.
  - `posicao_atual`=0, shadow=0, `ativo`=0, `largura`=LARGURA_MIN.
- Reset mid-pulse truncates the pulse; this is the only case where a pulse is truncated.

## Timing
- Load-to-effect latency runs from the `carrega` cycle to the first cycle of the following period. Worst case is PERIODO clocks; a bypass load in the `fim_periodo` cycle takes 1 clock.
- After reset, the first period always has `pwm`=0, because `ativo`=0. The first pulse appears in the period after that, provided `liga`=1 at the boundary.
- Within a period, the pulse is high for exactly `largura` consecutive clocks, starting at `cnt`=0.
- `posicao_atual` and `largura` change only in the first cycle of a period.
- `pendente` rises the cycle after `carrega` and falls the cycle after the boundary.

## Test plan
Use PERIODO=20, LARGURA_MIN=4, PASSO=2 for all scenarios.
1. Reset, then `liga`=1 held with no loads:
   - Period 1: `pwm`=0 throughout, `fim_periodo` pulses at `cnt`=19.
   - Period 2: `pwm` high for 4 clocks (`cnt` 0..3), `posicao_atual`=0.
2. `carrega` with `posicao`=5 at `cnt`=8:
   - The current period keeps width 4, and `pendente`=1 from `cnt`=9.
   - Next period: width 14, `posicao_atual`=5, `pendente`=0.
3. Loads of 3 at `cnt`=2 and 6 at `cnt`=10 in the same period:
   - Next period has width 16 and `posicao_atual`=6; position 3 is never applied.
4. `carrega` with `posicao`=7 in the `fim_periodo` cycle:
   - The very next cycle starts a period with width 18 and `posicao_atual`=7.
5. Disable and reset mid-pulse:
   - `liga`=0 at `cnt`=2 with width 14: the pulse still runs to `cnt`=13, and the following periods have `pwm`=0.
   - Separately, `zera_s` at `cnt`=5 mid-pulse: the next cycle shows `pwm`=0, `cnt`=0, `posicao_atual`=0.
6. Sweep driven by the position sequencer, loading 0..7..1 once per period (on `fim_periodo`):
   - Successive pulse widths are 4, 6, 8, 10, 12, 14, 16, 18, 16, 14, 12, 10, 8, 6.
